// File: rtl/preamble_inserter.sv
`timescale 1ns/1ps
// TX burst framer: short training field, long training field (cyclic prefix
// plus two symbols), payload pass-through, optional zero-sample guard gap.
module preamble_inserter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SHORT_PERIOD = 16,
    parameter int unsigned SHORT_LEN    = 160,
    parameter int unsigned LONG_PERIOD  = 64,
    parameter int unsigned LONG_CP      = 32,
    parameter int unsigned GAP_LEN      = 0,
    parameter logic [WIDTH*SHORT_PERIOD-1:0] SHORT_COEFFS = '0,
    parameter logic [WIDTH*LONG_PERIOD-1:0]  LONG_COEFFS  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_preamble
);

    localparam int unsigned LONG_LEN  = LONG_CP + 2 * LONG_PERIOD;
    localparam int unsigned MAX_SL    = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
    localparam int unsigned MAX_LEN   = (MAX_SL > GAP_LEN) ? MAX_SL : GAP_LEN;
    localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned SP_W      = (SHORT_PERIOD > 1) ? $clog2(SHORT_PERIOD) : 1;
    localparam int unsigned LP_W      = (LONG_PERIOD > 1) ? $clog2(LONG_PERIOD) : 1;
    localparam int unsigned SHORT_END = SHORT_LEN - 1;
    localparam int unsigned LONG_END  = LONG_LEN - 1;
    localparam int unsigned GAP_END   = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
    // Offset that makes the first LONG_CP samples replay the symbol tail.
    localparam int unsigned LONG_OFS  = (LONG_PERIOD - LONG_CP) % LONG_PERIOD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHORT,
        S_LONG,
        S_PAYLOAD,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             beat;

    logic [WIDTH-1:0] short_rom [SHORT_PERIOD];
    logic [WIDTH-1:0] long_rom  [LONG_PERIOD];
    logic [SP_W-1:0]  short_idx;
    logic [LP_W-1:0]  long_idx;

    // Unpack the constant coefficient vectors into sample-indexed tables.
    for (genvar k = 0; k < SHORT_PERIOD; k++) begin : g_short_rom
        assign short_rom[k] = SHORT_COEFFS[WIDTH*k +: WIDTH];
    end
    for (genvar k = 0; k < LONG_PERIOD; k++) begin : g_long_rom
        assign long_rom[k] = LONG_COEFFS[WIDTH*k +: WIDTH];
    end

    // Periods are powers of two, so the modulo is just the counter low bits.
    assign short_idx = cnt[SP_W-1:0];
    assign long_idx  = cnt[LP_W-1:0] + LP_W'(LONG_OFS);
    assign beat      = o_tvalid & o_tready;

    // Output decode from the registered state; payload is a straight pass-through.
    always_comb begin
        o_tdata    = '0;
        o_tvalid   = 1'b0;
        o_tlast    = 1'b0;
        o_preamble = 1'b0;
        i_tready   = 1'b0;
        case (state)
            S_SHORT: begin
                o_tvalid   = 1'b1;
                o_preamble = 1'b1;
                o_tdata    = short_rom[short_idx];
            end
            S_LONG: begin
                o_tvalid   = 1'b1;
                o_preamble = 1'b1;
                o_tdata    = long_rom[long_idx];
            end
            S_PAYLOAD: begin
                o_tdata  = i_tdata;
                o_tvalid = i_tvalid;
                o_tlast  = (GAP_LEN == 0) ? i_tlast : 1'b0;
                i_tready = o_tready;
            end
            S_GAP: begin
                o_tvalid = 1'b1;
                o_tlast  = (cnt == CNT_W'(GAP_END));
            end
            default: ;
        endcase
    end

    // State and sample counter; the counter only moves on an output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (i_tvalid) begin
                        state <= S_SHORT;
                    end
                end
                S_SHORT: begin
                    if (beat) begin
                        if (cnt == CNT_W'(SHORT_END)) begin
                            state <= S_LONG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_LONG: begin
                    if (beat) begin
                        if (cnt == CNT_W'(LONG_END)) begin
                            state <= S_PAYLOAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (beat && i_tlast) begin
                        cnt   <= '0;
                        state <= (GAP_LEN > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (beat) begin
                        if (cnt == CNT_W'(GAP_END)) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preamble_inserter.sv
`timescale 1ns/1ps
// Scoreboard bench for preamble_inserter: main instance without guard gap,
// second instance with an 8-sample guard gap.
module tb_preamble_inserter;

    localparam int unsigned W   = 32;
    localparam int unsigned SP  = 16;
    localparam int unsigned SL  = 160;
    localparam int unsigned LP  = 64;
    localparam int unsigned LCP = 32;
    localparam int unsigned GAP = 8;
    localparam int unsigned PRE = SL + LCP + 2 * LP;

    function automatic logic [W*SP-1:0] mk_short();
        logic [W*SP-1:0] v;
        v = '0;
        for (int k = 0; k < int'(SP); k++) v[W*k +: W] = W'(k + 1);
        return v;
    endfunction

    function automatic logic [W*LP-1:0] mk_long();
        logic [W*LP-1:0] v;
        v = '0;
        for (int k = 0; k < int'(LP); k++) v[W*k +: W] = W'(32'h100 + k);
        return v;
    endfunction

    localparam logic [W*SP-1:0] SC = mk_short();
    localparam logic [W*LP-1:0] LC = mk_long();

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] i_tdata;
    logic         i_tlast, i_tvalid, i_tready;
    logic [W-1:0] o_tdata;
    logic         o_tlast, o_tvalid, o_tready, o_preamble;
    logic [W-1:0] g_i_tdata;
    logic         g_i_tlast, g_i_tvalid, g_i_tready;
    logic [W-1:0] g_o_tdata;
    logic         g_o_tlast, g_o_tvalid, g_o_preamble;
    logic         g_o_tready = 1'b1;

    preamble_inserter #(
        .WIDTH(W), .SHORT_PERIOD(SP), .SHORT_LEN(SL), .LONG_PERIOD(LP),
        .LONG_CP(LCP), .GAP_LEN(0), .SHORT_COEFFS(SC), .LONG_COEFFS(LC)
    ) dut (
        .clk(clk), .reset(reset),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_preamble(o_preamble)
    );

    preamble_inserter #(
        .WIDTH(W), .SHORT_PERIOD(SP), .SHORT_LEN(SL), .LONG_PERIOD(LP),
        .LONG_CP(LCP), .GAP_LEN(GAP), .SHORT_COEFFS(SC), .LONG_COEFFS(LC)
    ) dut_gap (
        .clk(clk), .reset(reset),
        .i_tdata(g_i_tdata), .i_tlast(g_i_tlast), .i_tvalid(g_i_tvalid), .i_tready(g_i_tready),
        .o_tdata(g_o_tdata), .o_tlast(g_o_tlast), .o_tvalid(g_o_tvalid), .o_tready(g_o_tready),
        .o_preamble(g_o_preamble)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         pre;
    } beat_t;

    beat_t q[$];
    beat_t gq[$];

    int total = 0;
    int bad   = 0;
    int n_beats = 0;
    int burst_len = 0;
    int exp_burst_len = 0;
    int idle_run = 0;
    int g_len = 0;
    logic after_last = 1'b0;
    logic check_idle = 1'b0;
    logic rand_rdy   = 1'b0;
    logic g_after    = 1'b0;
    logic hold_v     = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic hold_l = 1'b0;

    // Output-ready driver: always ready, or a 50% random pattern.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Main monitor: stall stability, scoreboard pop, burst length, idle gap.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            hold_v = 1'b0;
            burst_len = 0;
            after_last = 1'b0;
        end else begin
            if (hold_v) begin
                total++;
                if (!o_tvalid || o_tdata !== hold_d || o_tlast !== hold_l) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b need v=1 d=%h l=%0b",
                             o_tvalid, o_tdata, o_tlast, hold_d, hold_l);
                end
            end
            hold_v = o_tvalid && !o_tready;
            hold_d = o_tdata;
            hold_l = o_tlast;
            if (!o_tvalid) idle_run++;
            if (o_tvalid && o_tready) begin
                if (after_last && check_idle) begin
                    total++;
                    if (idle_run != 1) begin
                        bad++;
                        $display("FAIL idle_gap: got %0d idle cycles need 1", idle_run);
                    end
                end
                after_last = 1'b0;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got d=%h with empty queue", o_tdata);
                end else begin
                    e = q.pop_front();
                    if ({o_tdata, o_tlast, o_preamble} !== {e.data, e.last, e.pre}) begin
                        bad++;
                        $display("FAIL beat%0d: got d=%h l=%0b p=%0b need d=%h l=%0b p=%0b",
                                 n_beats, o_tdata, o_tlast, o_preamble, e.data, e.last, e.pre);
                    end
                end
                n_beats++;
                burst_len++;
                if (o_tlast) begin
                    total++;
                    if (burst_len != exp_burst_len) begin
                        bad++;
                        $display("FAIL burst_len: got %0d need %0d", burst_len, exp_burst_len);
                    end
                    burst_len = 0;
                    after_last = 1'b1;
                    idle_run = 0;
                end
            end
        end
    end

    // Guard-gap monitor: scoreboard pop, burst length, valid drops after tlast.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            g_len = 0;
            g_after = 1'b0;
        end else begin
            if (g_after) begin
                total++;
                if (g_o_tvalid) begin
                    bad++;
                    $display("FAIL gap_end_idle: got o_tvalid=1 need 0");
                end
                g_after = 1'b0;
            end
            if (g_o_tvalid && g_o_tready) begin
                total++;
                if (gq.size() == 0) begin
                    bad++;
                    $display("FAIL gap_unexpected_beat: got d=%h with empty queue", g_o_tdata);
                end else begin
                    e = gq.pop_front();
                    if ({g_o_tdata, g_o_tlast, g_o_preamble} !== {e.data, e.last, e.pre}) begin
                        bad++;
                        $display("FAIL gap_beat%0d: got d=%h l=%0b p=%0b need d=%h l=%0b p=%0b",
                                 g_len, g_o_tdata, g_o_tlast, g_o_preamble, e.data, e.last, e.pre);
                    end
                end
                g_len++;
                if (g_o_tlast) begin
                    total++;
                    if (g_len != int'(PRE + 5 + GAP)) begin
                        bad++;
                        $display("FAIL gap_burst_len: got %0d need %0d", g_len, PRE + 5 + GAP);
                    end
                    g_len = 0;
                    g_after = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h need %h", name, got, exp);
        end
    endtask

    task automatic push(input int which, input logic [W-1:0] d, input logic l, input logic p);
        beat_t e;
        e.data = d;
        e.last = l;
        e.pre  = p;
        if (which == 0) q.push_back(e);
        else gq.push_back(e);
    endtask

    // Short field 1..16 repeated, then prefix 0x120..0x13F, then 0x100..0x13F twice.
    task automatic push_pre(input int which);
        for (int k = 0; k < int'(SL); k++) push(which, W'((k % 16) + 1), 1'b0, 1'b1);
        for (int k = 0; k < int'(LCP); k++) push(which, W'(32'h120 + k), 1'b0, 1'b1);
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < int'(LP); k++) push(which, W'(32'h100 + k), 1'b0, 1'b1);
    endtask

    task automatic expect_pkt(input int which, input int n, input logic [W-1:0] base);
        push_pre(which);
        for (int i = 0; i < n; i++)
            push(which, base + W'(i), (which == 0) && (i == n - 1), 1'b0);
        if (which != 0)
            for (int i = 0; i < int'(GAP); i++) push(which, '0, i == int'(GAP) - 1, 1'b0);
    endtask

    // Present n payload samples, each held until the DUT accepts it.
    task automatic drive_pkt(input int which, input int n, input logic [W-1:0] base);
        int c;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin
                i_tdata = base + W'(i); i_tlast = (i == n - 1); i_tvalid = 1'b1;
            end else begin
                g_i_tdata = base + W'(i); g_i_tlast = (i == n - 1); g_i_tvalid = 1'b1;
            end
            c = 0;
            do begin
                @(negedge clk);
                c++;
                rdy = (which == 0) ? i_tready : g_i_tready;
            end while (!rdy && c < 3000);
            if (!rdy) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got no i_tready in %0d cycles need accept", c);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int which);
        int c;
        c = 0;
        while (((which == 0) ? q.size() : gq.size()) != 0 && c < 5000) begin
            @(negedge clk);
            #1;
            c++;
        end
        total++;
        if (((which == 0) ? q.size() : gq.size()) != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending need 0",
                     (which == 0) ? q.size() : gq.size());
        end
    endtask

    task automatic wait_beats(input int target);
        int c;
        c = 0;
        while (n_beats < target && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        total++;
        if (n_beats < target) begin
            bad++;
            $display("FAIL beat_wait_timeout: got %0d beats need %0d", n_beats, target);
        end
    endtask

    initial begin
        int nb0;
        reset = 1'b1;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        g_i_tdata = '0; g_i_tlast = 1'b0; g_i_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", W'(o_tvalid), '0);
        chk("rst_tlast", W'(o_tlast), '0);
        chk("rst_preamble", W'(o_preamble), '0);
        chk("rst_itready", W'(i_tready), '0);
        chk("rst_tdata", o_tdata, '0);
        chk("rst_gap_tvalid", W'(g_o_tvalid), '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 10-sample packet, always ready; 1-cycle start latency.
        exp_burst_len = int'(PRE) + 10;
        expect_pkt(0, 10, W'(32'hA000));
        fork
            drive_pkt(0, 10, W'(32'hA000));
            begin
                @(negedge clk);
                chk("start_idle_tvalid", W'(o_tvalid), '0);
                @(negedge clk);
                chk("start_first_tvalid", W'(o_tvalid), W'(1));
                chk("start_first_tdata", o_tdata, W'(1));
            end
        join
        i_tvalid = 1'b0;
        wait_drain(0);
        @(negedge clk);
        chk("post_burst_tvalid", W'(o_tvalid), '0);
        @(posedge clk);
        #1;

        // Same packet with random backpressure.
        rand_rdy = 1'b1;
        expect_pkt(0, 10, W'(32'hB000));
        drive_pkt(0, 10, W'(32'hB000));
        i_tvalid = 1'b0;
        wait_drain(0);
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Two back-to-back 4-sample packets, i_tvalid held high throughout.
        exp_burst_len = int'(PRE) + 4;
        expect_pkt(0, 4, W'(32'hC000));
        expect_pkt(0, 4, W'(32'hC100));
        nb0 = n_beats;
        fork
            begin
                drive_pkt(0, 4, W'(32'hC000));
                drive_pkt(0, 4, W'(32'hC100));
            end
            begin
                wait_beats(nb0 + 1);
                check_idle = 1'b1;
            end
        join
        i_tvalid = 1'b0;
        wait_drain(0);
        check_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after 50 short beats, then a clean 3-sample packet.
        for (int k = 0; k < 50; k++) push(0, W'((k % 16) + 1), 1'b0, 1'b1);
        i_tdata = W'(32'hD000); i_tlast = 1'b0; i_tvalid = 1'b1;
        nb0 = n_beats;
        wait_beats(nb0 + 50);
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_tvalid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("abort_tvalid", W'(o_tvalid), '0);
        chk("abort_itready", W'(i_tready), '0);
        chk("abort_tlast", W'(o_tlast), '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_burst_len = int'(PRE) + 3;
        expect_pkt(0, 3, W'(32'hE000));
        drive_pkt(0, 3, W'(32'hE000));
        i_tvalid = 1'b0;
        wait_drain(0);
        repeat (2) @(posedge clk);
        #1;

        // Single-sample payload whose valid arrives late.
        exp_burst_len = int'(PRE) + 1;
        expect_pkt(0, 1, W'(32'hF000));
        i_tdata = W'(32'hF000); i_tlast = 1'b1; i_tvalid = 1'b1;
        nb0 = n_beats;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        wait_beats(nb0 + int'(PRE));
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("late_stall_tvalid", W'(o_tvalid), '0);
            chk("late_stall_itready", W'(i_tready), W'(1));
        end
        @(posedge clk);
        #1;
        drive_pkt(0, 1, W'(32'hF000));
        i_tvalid = 1'b0;
        wait_drain(0);
        @(negedge clk);
        chk("late_post_tvalid", W'(o_tvalid), '0);

        // Guard-gap instance: 5-sample payload followed by 8 zeros.
        @(posedge clk);
        #1;
        expect_pkt(1, 5, W'(32'h5000));
        drive_pkt(1, 5, W'(32'h5000));
        g_i_tvalid = 1'b0;
        wait_drain(1);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion need finish before 1ms");
        $fatal(1);
    end

endmodule
